// File: rtl/pe_pkg.sv
// Shared types, default widths and saturation bounds for the PE weight MAC.
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_ACC_W  = 20;
    localparam int unsigned DEF_CNT_W  = 8;

    function automatic longint SAT_MAX(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint SAT_MIN(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/pe_weight_rf.sv
// Signed weight register file: async-clear, synchronous write, combinational read
// on the same shared address.
module pe_weight_rf
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic signed [DATA_W-1:0] wdata,
    output logic signed [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic signed [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read returns the pre-write value when a write hits the same address.
    assign rdata = mem[addr];

endmodule

// File: rtl/pe_weight_mac.sv
// Weight-stationary MAC: two-stage multiply/accumulate over a processing window.
// Build option PE_MAC_SAT_EN: saturating accumulation plus sticky sat_flag output.
module pe_weight_mac
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     weight_in_valid,
    input  logic signed [DATA_W-1:0] weight_in,
    input  logic [ADDR_W-1:0]        weight_addr,
    input  logic                     process_enable,
    input  logic                     act_valid,
    input  logic signed [DATA_W-1:0] act_in,
    output logic                     busy,
    output logic                     result_valid,
    output logic signed [ACC_W-1:0]  result,
    output logic [CNT_W-1:0]         mac_count
`ifdef PE_MAC_SAT_EN
    ,
    output logic                     sat_flag
`endif
);

    state_e                     state, state_nxt;
    logic signed [DATA_W-1:0]   w_rd;
    logic                       accept;
    logic signed [2*DATA_W-1:0] mul;
    logic signed [ACC_W-1:0]    prod_r;
    logic                       prod_v;
    logic signed [ACC_W-1:0]    acc, acc_nxt;
    logic [CNT_W-1:0]           beat_cnt;

    pe_weight_rf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (weight_in_valid),
        .addr  (weight_addr),
        .wdata (weight_in),
        .rdata (w_rd)
    );

    assign accept = process_enable && act_valid && (state == IDLE || state == ACCUM);
    assign mul    = act_in * w_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (process_enable)  state_nxt = ACCUM;
            ACCUM:   if (!process_enable) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_r <= '0;
            prod_v <= 1'b0;
        end else begin
            prod_r <= ACC_W'(mul);
            prod_v <= accept;
        end
    end

`ifdef PE_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(SAT_MAX(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(SAT_MIN(ACC_W));

    logic [ACC_W:0] sum_ext;
    logic           sat_hit;

    // One guard bit: overflow when the two top bits of the widened sum disagree.
    always_comb begin
        sum_ext = {acc[ACC_W-1], acc} + {prod_r[ACC_W-1], prod_r};
        sat_hit = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
        acc_nxt = sum_ext[ACC_W-1:0];
        if (sat_hit) acc_nxt = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    sat_flag <= 1'b0;
        else if (state == DONE)      sat_flag <= 1'b0;
        else if (prod_v && sat_hit)  sat_flag <= 1'b1;
    end
`else
    assign acc_nxt = acc + prod_r;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            beat_cnt <= '0;
        end else if (state == DONE) begin
            acc      <= '0;
            beat_cnt <= '0;
        end else if (prod_v) begin
            acc <= acc_nxt;
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // DRAIN gives the final product one cycle to land before publishing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result    <= '0;
            mac_count <= '0;
        end else if (state == DRAIN) begin
            result    <= acc;
            mac_count <= beat_cnt;
        end
    end

    assign result_valid = (state == DONE);
    assign busy         = (state == DRAIN) || (state == DONE);

endmodule

// File: doc/pe_weight_mac.md
Name: pe_weight_mac

Overview:
- Downstream consumer of the PE controller. It takes weight_in_valid, weight_addr and process_enable from the controller.
- Holds a small signed weight register file. While process_enable is high, it multiplies each streamed activation by the addressed weight and accumulates the products.
- When a processing window closes, it emits one accumulated result with a single-cycle valid pulse. This result feeds the PE output/writeback stage.

Parameters:
- DATA_W, 8, signed width of weights and activations
- ADDR_W, 4, weight address width; depth is 2**ADDR_W = 16 entries
- ACC_W, 20, signed accumulator and result width; must be >= 2*DATA_W
- CNT_W, 8, width of the accepted-beat counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- weight_in_valid  in  1  write strobe for the weight register file
- weight_in  in  DATA_W  signed weight write data
- weight_addr  in  ADDR_W  weight address, shared by write and MAC read
- process_enable  in  1  processing window, level
- act_valid  in  1  activation beat qualifier
- act_in  in  DATA_W  signed activation
- busy  out  1  high in DRAIN or DONE; new windows are not accepted
- result_valid  out  1  single-cycle pulse
- result  out  ACC_W  signed accumulated sum, held until the next DONE
- mac_count  out  CNT_W  accepted beats in the last window, held with result

Behaviour:
- Reset (rst low, async) clears the following, regardless of state:
  - all weights to 0
  - accumulator and product pipeline
  - FSM to IDLE
  - result_valid, result, mac_count, busy to 0
- Weight write: on weight_in_valid at an edge, mem[weight_addr] <= weight_in. Writes are accepted in every state.
- Same-cycle write and MAC read of one address: the MAC reads the OLD value (read-before-write).
- Beat acceptance: process_enable && act_valid && (state==IDLE || state==ACCUM).
- Stage 1: prod_r <= sext(act_in * mem[weight_addr]) to ACC_W; prod_v <= accepted.
- Stage 2: on prod_v, acc <= acc + prod_r and beat counter increments.
  - Beat counter saturates at 2**CNT_W-1.
- FSM (registered):
  - IDLE: process_enable=1 -> ACCUM. The beat in that cycle is accepted.
  - ACCUM: process_enable=0 -> DRAIN.
  - DRAIN: lasts one cycle, which lets the last product land in acc. On exit, result <= acc and mac_count <= counter. -> DONE.
  - DONE: result_valid=1 for this cycle only. acc and counter are cleared to 0. -> IDLE.
- Latency: last beat sampled at edge N, process_enable low at edge N+1 -> result_valid high from edge N+2 to edge N+3.
- Empty window (no act_valid): result=0, mac_count=0.
- process_enable high during DRAIN/DONE: ignored, and no beats are accepted. If it is still high on return to IDLE, a new window starts there.
- Arithmetic: signed multiply to 2*DATA_W, sign-extended to ACC_W. Without the optional feature, accumulation wraps two's-complement.

Optional Feature:
- Macro: PE_MAC_SAT_EN
- Defined: stage-2 add saturates to [-2**(ACC_W-1), 2**(ACC_W-1)-1]. The sticky output sat_flag (1 bit, added port) is set on any clipped add in the window. It is cleared in DONE after being published alongside result.
- Undefined: wraps; no sat_flag port.

Decomposition:
- Package pe_pkg holds:
  - the FSM state enum: IDLE, ACCUM, DRAIN, DONE
  - default widths DATA_W, ADDR_W, ACC_W, CNT_W
  - the SAT_MAX/SAT_MIN constant functions
- One sub-module: pe_weight_rf. It is the 16x DATA_W register file, with async-reset, a synchronous write and a combinational read port.
- FSM, pipeline and accumulator stay in pe_weight_mac.

Test Plan:
- Reset mid-window: write mem[3]=5, stream 4 beats, then pull rst low for 1 cycle. Required: result_valid never fires, busy=0, mem[3] reads 0 in a following window (act=1 -> result 0).
- Basic MAC: load mem[0..3]={1,2,3,4}; window with act {10,10,10,10} at addr 0..3. Required: result=100, mac_count=4, result_valid exactly 2 cycles after the last beat edge, width 1 cycle.
- Signed/empty: mem[5]=-3, acts {7,-2} -> result=-15, mac_count=2. Then a window with no act_valid -> result=0, mac_count=0.
- Write/read collision: mem[2]=6; same cycle write mem[2]=9 and a beat act=1 at addr 2, then a second beat act=1 at addr 2. Required: result=15.
- Back-to-back: process_enable dropped for 1 cycle then re-raised. Required: beats during DRAIN/DONE ignored (busy=1). The new window starts in IDLE and the second result excludes the first window's sum.
- PE_MAC_SAT_EN: mem[0]=-128, 32 beats act=-128 (sum 524288). With macro: result=524287, sat_flag=1. Without: result=-524288.
